// File: rtl/shift_unit_seq_pkg.sv
// Shared encodings for the multi-cycle shifter: op modes, FSM states and a
// helper that gives the number of RUN steps for a given shift amount.
package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_LUI = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of RUN edges needed to consume a shift amount, step bits at a time.
    function automatic int step_cnt(input int shamt, input int step = 4);
        return (shamt + step - 1) / step;
    endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Start/busy/done request bus between the control FSM (master) and the
// multi-cycle shifter (slave).
interface shift_unit_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic [SW-1:0]    shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, mode, din, shamt,
        input  busy, done, dout
    );

    modport slave (
        input  start, mode, din, shamt,
        output busy, done, dout
    );

endinterface

// File: rtl/shift_unit_seq_step.sv
// Combinational single-step shifter: shifts or rotates by k (0..STEP) bits.
// Rotate modes exist only when SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]           i_in,
    input  logic [$clog2(STEP+1)-1:0]  i_k,
    input  logic [2:0]                 i_mode,
    output logic [WIDTH-1:0]           o_out
);

    // NOTE: o_out gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        o_out = i_in;
        case (i_mode)
            MODE_SLL: o_out = i_in << i_k;
            MODE_SRL: o_out = i_in >> i_k;
            MODE_SRA: o_out = $signed(i_in) >>> i_k;
`ifdef SHIFT_ROTATE_EN
            // A shift by WIDTH yields zero, so k==0 rotates cleanly to a passthrough.
            MODE_ROL: o_out = (i_in << i_k) | (i_in >> (WIDTH - int'(i_k)));
            MODE_ROR: o_out = (i_in >> i_k) | (i_in << (WIDTH - int'(i_k)));
`endif
            default:  o_out = i_in;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA shifter (STEP bits per cycle) with single-pass LUI.
// Optional rotate modes controlled by macro SHIFT_ROTATE_EN.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    shift_unit_seq_if.slave  bus
);

    localparam int SW = $clog2(WIDTH);
    localparam int KW = $clog2(STEP + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_dout;
    logic [SW-1:0]    r_rem;
    logic [SW-1:0]    w_rem_nxt;
    logic [KW-1:0]    w_k;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_lui;
    logic             w_fast;
    logic             w_last;

    function automatic logic is_run_mode(input logic [2:0] m);
`ifdef SHIFT_ROTATE_EN
        return m inside {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR};
`else
        return m inside {MODE_SLL, MODE_SRL, MODE_SRA};
`endif
    endfunction

    // LUI, reserved modes and zero shifts all finish in the accepting edge.
    assign w_fast = !is_run_mode(bus.mode) || (bus.shamt == '0);
    assign w_lui  = {bus.din[IMM_W-1:0], {(WIDTH-IMM_W){1'b0}}};

    always_comb begin
        if (int'(r_rem) >= STEP) w_k = KW'(STEP);
        else                     w_k = KW'(r_rem);
    end

    assign w_rem_nxt = r_rem - SW'(w_k);
    assign w_last    = (w_rem_nxt == '0);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_in   (r_acc),
        .i_k    (w_k),
        .i_mode (r_mode),
        .o_out  (w_acc_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = w_fast ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_acc  <= bus.din;
                        r_rem  <= bus.shamt;
                        if (w_fast) r_dout <= (bus.mode == MODE_LUI) ? w_lui : bus.din;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    if (w_last) r_dout <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.dout = r_dout;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus randomized ops
// against an arithmetic reference model (rotate expectations follow SHIFT_ROTATE_EN).
module tb_shift_unit_seq;
    import shift_pkg::*;

    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    shift_unit_seq_if #(.WIDTH(32)) bus ();

    shift_unit_seq #(.WIDTH(32), .STEP(STEP), .IMM_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic rot_en();
`ifdef SHIFT_ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] m, input logic [31:0] d, input int s);
        case (m)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return $signed(d) >>> s;
            3'd3: return {d[15:0], 16'h0000};
            3'd4: return (!rot_en() || s == 0) ? d : ((d << s) | (d >> (32 - s)));
            3'd5: return (!rot_en() || s == 0) ? d : ((d >> s) | (d << (32 - s)));
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] m, input int s);
        if (m == 3'd3 || m >= 3'd6 || s == 0) return 1;
        if (m >= 3'd4 && !rot_en()) return 1;
        return step_cnt(s, STEP) + 1;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
    task automatic do_op(input logic [2:0] m, input logic [31:0] d, input logic [4:0] s,
                         input string tag);
        logic [31:0] prev, res;
        int lat, bcyc;
        logic got, both, hold_bad;
        prev = bus.dout;
        bus.start = 1'b1; bus.mode = m; bus.din = d; bus.shamt = s;
        @(posedge clk);
        lat = 0; bcyc = 0; got = 0; both = 0; hold_bad = 0; res = '0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            lat++;
            if (bus.busy && bus.done) both = 1;
            if (bus.done) begin
                got = 1;
                res = bus.dout;
            end else begin
                if (bus.busy) bcyc++;
                if (bus.dout !== prev) hold_bad = 1;
            end
            // Garbage on the inputs while busy/done must be ignored.
            bus.start = 1'($urandom_range(0, 1));
            bus.mode  = 3'($urandom);
            bus.din   = $urandom;
            bus.shamt = 5'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_res"}, res, model_res(m, d, int'(s)));
        check({tag, "_lat"}, 32'(lat), 32'(model_lat(m, int'(s))));
        check({tag, "_busy"}, 32'(bcyc), 32'(model_lat(m, int'(s)) - 1));
        check({tag, "_flags"}, {30'd0, both, hold_bad}, 32'd0);
        check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] d_seq [3];
        logic        got, seen;

        rst = 1'b1;
        bus.start = 1'b0; bus.mode = '0; bus.din = '0; bus.shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_flags", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset_dout", bus.dout, 32'd0);

        do_op(MODE_SLL, 32'h0000_0001, 5'd31, "sll31");
        do_op(MODE_SRA, 32'h8000_00F0, 5'd5, "sra5");
        check("sra5_const", bus.dout, 32'hFC00_0007);
        do_op(MODE_SRL, 32'h8000_00F0, 5'd5, "srl5");
        check("srl5_const", bus.dout, 32'h0400_0007);
        do_op(MODE_LUI, 32'hDEAD_1234, 5'd7, "lui");
        check("lui_const", bus.dout, 32'h1234_0000);
        do_op(MODE_SLL, 32'hA5A5_0001, 5'd0, "sll0");
        do_op(3'b110, 32'h1357_9BDF, 5'd9, "rsvd");

        // Reset while in RUN: no result and no done pulse afterwards.
        bus.start = 1'b1; bus.mode = MODE_SLL; bus.din = 32'h0000_0003; bus.shamt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("rstrun_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstrun_flags", {30'd0, bus.busy, bus.done}, 32'd0);
        check("rstrun_dout", bus.dout, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        check("rstrun_quiet", {31'd0, seen}, 32'd0);
        do_op(MODE_SLL, 32'h0000_0003, 5'd20, "after_rst");

        // start held high: back-to-back SRL ops with one IDLE cycle between them.
        d_seq[0] = 32'hCAFE_F00D; d_seq[1] = 32'h1234_5678; d_seq[2] = 32'hFFFF_0000;
        bus.start = 1'b1; bus.mode = MODE_SRL; bus.shamt = 5'd8; bus.din = d_seq[0];
        for (int i = 0; i < 3; i++) begin
            got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (bus.done) got = 1;
                else bus.din = $urandom;
            end
            check($sformatf("b2b%0d_res", i), bus.dout, d_seq[i] >> 8);
            if (i < 2) bus.din = d_seq[i+1];
            else       bus.start = 1'b0;
            @(negedge clk);
            check($sformatf("b2b%0d_gap", i), {30'd0, bus.busy, bus.done}, 32'd0);
            if (i < 2) begin
                @(negedge clk);
                check($sformatf("b2b%0d_accept", i), {31'd0, bus.busy}, 32'd1);
                bus.din = $urandom;
            end
        end

        do_op(MODE_ROR, 32'h0000_000F, 5'd4, "ror4");
        check("ror4_const", bus.dout, rot_en() ? 32'hF000_0000 : 32'h0000_000F);
        do_op(MODE_ROL, 32'h8000_0001, 5'd3, "rol3");

        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
                  $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
